// File: rtl/oam_dma_engine.sv
// OAM DMA controller: copies XFER_LEN bytes from page {src_hi,00} into OAM at OAM_BASE.
// Optional build macro OAM_DMA_ECHO_MAP_EN mirrors source pages 0xE0-0xFF down to 0xC0-0xDF.
module oam_dma_engine #(
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          XFER_LEN     = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  reg_rdata,
  output logic        reg_rd_hit,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  input  logic [7:0]  dma_rdata,
  output logic        dma_wr,
  output logic [7:0]  dma_wdata,
  output logic        cpu_block,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_READ,
    S_WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] dma_reg;
  logic [7:0] src_hi;
  logic       done_nxt;
  logic       reg_wr;
  logic       reg_rd;

  assign reg_wr = cpu_wr && (cpu_addr == DMA_REG_ADDR);
  assign reg_rd = cpu_rd && (cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ECHO_MAP_EN
  assign src_hi = (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;
`else
  assign src_hi = dma_reg;
`endif

  // The registered source memory returns data in the WRITE cycle, so it passes straight through.
  assign dma_wdata = dma_rdata;

  // NOTE: all state updates here use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 8'h00;
      dma_reg    <= 8'hFF;
      done       <= 1'b0;
      reg_rdata  <= 8'hFF;
      reg_rd_hit <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      done       <= done_nxt;
      reg_rd_hit <= reg_rd;
      if (reg_wr) dma_reg <= cpu_wdata;
      if (reg_rd) reg_rdata <= dma_reg;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    dma_addr  = 16'h0000;
    dma_rd    = 1'b0;
    dma_wr    = 1'b0;
    cpu_block = 1'b1;

    unique case (state)
      S_IDLE: begin
        cpu_block = 1'b0;
      end
      S_START: begin
        state_nxt = S_READ;
      end
      S_READ: begin
        dma_addr  = {src_hi, idx};
        dma_rd    = 1'b1;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        dma_addr = OAM_BASE + {8'h00, idx};
        dma_wr   = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt   = idx + 8'h01;
          state_nxt = S_READ;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // A register write (re)starts the copy from any state and overrides a same-cycle completion.
    if (reg_wr) begin
      state_nxt = S_START;
      idx_nxt   = 8'h00;
      done_nxt  = 1'b0;
    end
  end

endmodule
